// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: hazard and bypass controller for the 5-stage MIPS32 pipeline.
// Tracks register metadata for the EX, MEM and WB slots in a shadow pipeline.
// Uses that metadata to drive the EX forward selects, load-use stalls and
// branch flushes, and to freeze the whole pipeline while a multi-cycle data
// memory access completes.
module hazard_forward_ctrl #(
    parameter int REG_AW  = 5,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 3,
    parameter int STAT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              branch_taken,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              ctrl_sel,
    output logic              mem_stall,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic [STAT_W-1:0] load_use_cnt,
    output logic [STAT_W-1:0] mem_stall_cnt
);

    // Reject parameter sets the wait counter cannot represent.
    if (MEM_LAT < 1 || MEM_LAT > 8 || (MEM_LAT - 1) >= (1 << CNT_W)) begin : g_bad_params
        $error("hazard_forward_ctrl: MEM_LAT must be 1..8 and fit in CNT_W bits");
    end

    // Reload value for the wait counter; 0 means a single-cycle MEM.
    localparam logic [CNT_W-1:0] MEM_WAIT = CNT_W'(MEM_LAT - 1);

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic              rw;
        logic              mr;
        logic              mw;
    } ex_slot_t;

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              rw;
        logic              mr;
        logic              mw;
    } mem_slot_t;

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              rw;
    } wb_slot_t;

    ex_slot_t         ex_q;
    mem_slot_t        mem_q;
    wb_slot_t         wb_q;
    logic [CNT_W-1:0] wait_cnt;

    ex_slot_t id_slot;
    logic     mem_memop;
    logic     ex_memop;
    logic     frozen;
    logic     flush;
    logic     ex_load_dst;
    logic     lu_hazard;
    logic     load_use;

    // EX-stage bypass select for one source operand. A load still in MEM has
    // no data yet, so it only becomes a source once it reaches WB.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input mem_slot_t         m,
        input wb_slot_t          w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (m.v && m.rw && !m.mr && (m.rd != '0) && (m.rd == src))
            sel = 2'b10;
        else if (w.v && w.rw && (w.rd != '0) && (w.rd == src))
            sel = 2'b01;
        return sel;
    endfunction

    // Hazard decode from the registered slots and the instruction in ID.
    always_comb begin
        id_slot     = '0;
        id_slot.v   = id_valid;
        id_slot.rs  = id_rs;
        id_slot.rt  = id_rt;
        id_slot.rd  = id_rd;
        id_slot.rw  = id_regwrite;
        id_slot.mr  = id_memread;
        id_slot.mw  = id_memwrite;

        mem_memop   = mem_q.v && (mem_q.mr || mem_q.mw);
        ex_memop    = ex_q.v && (ex_q.mr || ex_q.mw);
        // A nonzero count only ever exists with a memory op parked in MEM;
        // gating on it keeps a stray count from freezing an empty pipe.
        frozen      = (wait_cnt != '0) && mem_memop;
        flush       = !frozen && branch_taken;
        ex_load_dst = ex_q.v && ex_q.mr && ex_q.rw && (ex_q.rd != '0);
        lu_hazard   = id_valid && ex_load_dst &&
                      ((ex_q.rd == id_rs) || (id_uses_rt && (ex_q.rd == id_rt)));
        load_use    = !frozen && !flush && lu_hazard;
    end

    // Pipeline enables, bubble select and bypass selects; reset forces the
    // free-running defaults so the datapath is never held during reset.
    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        ctrl_sel   = 1'b1;
        mem_stall  = 1'b0;
        forward_a  = 2'b00;
        forward_b  = 2'b00;
        if (!reset) begin
            forward_a = fwd_sel(ex_q.rs, mem_q, wb_q);
            forward_b = fwd_sel(ex_q.rt, mem_q, wb_q);
            if (frozen) begin
                mem_stall  = 1'b1;
                pc_write   = 1'b0;
                ifid_write = 1'b0;
            end else if (flush) begin
                ifid_flush = 1'b1;
                ctrl_sel   = 1'b0;
            end else if (load_use) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                ctrl_sel   = 1'b0;
            end
        end
    end

    // Shadow slot pipeline: hold EX/MEM and drain WB while frozen, otherwise
    // advance with a bubble into EX on a flush or load-use stall.
    always_ff @(posedge clock) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (frozen) begin
            wb_q <= '0;
        end else begin
            ex_q      <= (flush || load_use) ? '0 : id_slot;
            mem_q.v   <= ex_q.v;
            mem_q.rd  <= ex_q.rd;
            mem_q.rw  <= ex_q.rw;
            mem_q.mr  <= ex_q.mr;
            mem_q.mw  <= ex_q.mw;
            wb_q.v    <= mem_q.v;
            wb_q.rd   <= mem_q.rd;
            wb_q.rw   <= mem_q.rw;
        end
    end

    // Memory wait counter: loads when a memory op moves into MEM and counts
    // the extra cycles it must stay there.
    always_ff @(posedge clock) begin
        if (reset)
            wait_cnt <= '0;
        else if (frozen)
            wait_cnt <= wait_cnt - CNT_W'(1);
        else if (ex_memop)
            wait_cnt <= MEM_WAIT;
        else
            wait_cnt <= '0;
    end

    // Saturating count of load-use stall cycles.
    always_ff @(posedge clock) begin
        if (reset)
            load_use_cnt <= '0;
        else if (load_use && (load_use_cnt != '1))
            load_use_cnt <= load_use_cnt + STAT_W'(1);
    end

    // Saturating count of memory freeze cycles.
    always_ff @(posedge clock) begin
        if (reset)
            mem_stall_cnt <= '0;
        else if (frozen && (mem_stall_cnt != '1))
            mem_stall_cnt <= mem_stall_cnt + STAT_W'(1);
    end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench for hazard_forward_ctrl. Three instances share the ID
// stimulus: MEM_LAT=1, MEM_LAT=3, and MEM_LAT=4 with 2-bit statistics.
// Each test task pushes the expected control word before the cycle and pops
// and compares it when the outputs are sampled on the falling edge.
module tb_hazard_forward_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_uses_rt, id_regwrite, id_memread, id_memwrite;
    logic       branch_taken;

    always #5 clock = ~clock;

    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urt;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       mw;
        logic       bt;
    } ins_t;

    // Control word: {pc_write, ifid_write, ifid_flush, ctrl_sel, mem_stall, fa, fb}
    localparam logic [8:0] NRM = 9'b1_1_0_1_0_00_00;
    localparam logic [8:0] LUS = 9'b0_0_0_0_0_00_00;
    localparam logic [8:0] FRZ = 9'b0_0_0_1_1_00_00;
    localparam logic [8:0] FLS = 9'b1_1_1_0_0_00_00;
    localparam logic [8:0] FA_EXM = 9'b0_0_0_0_0_10_00;
    localparam logic [8:0] FA_WB  = 9'b0_0_0_0_0_01_00;

    logic [8:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    logic        pw1, iw1, fl1, cs1, ms1;
    logic [1:0]  fa1, fb1;
    logic [15:0] lu1, mc1;
    logic        pw3, iw3, fl3, cs3, ms3;
    logic [1:0]  fa3, fb3;
    logic [15:0] lu3, mc3;
    logic        pw4, iw4, fl4, cs4, ms4;
    logic [1:0]  fa4, fb4;
    logic [1:0]  lu4, mc4;
    logic [8:0]  o1, o3, o4;

    assign o1 = {pw1, iw1, fl1, cs1, ms1, fa1, fb1};
    assign o3 = {pw3, iw3, fl3, cs3, ms3, fa3, fb3};
    assign o4 = {pw4, iw4, fl4, cs4, ms4, fa4, fb4};

    hazard_forward_ctrl #(.REG_AW(5), .MEM_LAT(1), .CNT_W(3), .STAT_W(16)) u1 (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite), .branch_taken(branch_taken),
        .pc_write(pw1), .ifid_write(iw1), .ifid_flush(fl1), .ctrl_sel(cs1), .mem_stall(ms1),
        .forward_a(fa1), .forward_b(fb1), .load_use_cnt(lu1), .mem_stall_cnt(mc1));

    hazard_forward_ctrl #(.REG_AW(5), .MEM_LAT(3), .CNT_W(3), .STAT_W(16)) u3 (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite), .branch_taken(branch_taken),
        .pc_write(pw3), .ifid_write(iw3), .ifid_flush(fl3), .ctrl_sel(cs3), .mem_stall(ms3),
        .forward_a(fa3), .forward_b(fb3), .load_use_cnt(lu3), .mem_stall_cnt(mc3));

    hazard_forward_ctrl #(.REG_AW(5), .MEM_LAT(4), .CNT_W(3), .STAT_W(2)) u4 (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite), .branch_taken(branch_taken),
        .pc_write(pw4), .ifid_write(iw4), .ifid_flush(fl4), .ctrl_sel(cs4), .mem_stall(ms4),
        .forward_a(fa4), .forward_b(fb4), .load_use_cnt(lu4), .mem_stall_cnt(mc4));

    function automatic ins_t mk(input logic v, input int rs, input int rt, input logic urt,
                                input int rd, input logic rw, input logic mr, input logic mw,
                                input logic bt);
        ins_t i;
        i.v = v; i.rs = 5'(rs); i.rt = 5'(rt); i.urt = urt; i.rd = 5'(rd);
        i.rw = rw; i.mr = mr; i.mw = mw; i.bt = bt;
        return i;
    endfunction

    task automatic drive(input ins_t i);
        id_valid = i.v; id_rs = i.rs; id_rt = i.rt; id_uses_rt = i.urt; id_rd = i.rd;
        id_regwrite = i.rw; id_memread = i.mr; id_memwrite = i.mw; branch_taken = i.bt;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [8:0] e;
        reset = 1'b1;
        drive(mk(1, 2, 2, 1, 2, 1, 1, 0, 1));
        @(posedge clock); #1;
        exp_q.push_back(NRM); exp_q.push_back(NRM); exp_q.push_back(NRM);
        @(negedge clock);
        e = exp_q.pop_front(); checks++;
        if (o1 !== e) begin errors++; $display("FAIL reset_out_u1: got %b want %b", o1, e); end
        e = exp_q.pop_front(); checks++;
        if (o3 !== e) begin errors++; $display("FAIL reset_out_u3: got %b want %b", o3, e); end
        e = exp_q.pop_front(); checks++;
        if (o4 !== e) begin errors++; $display("FAIL reset_out_u4: got %b want %b", o4, e); end
        checks++;
        if (lu1 !== 16'd0 || mc1 !== 16'd0 || lu4 !== 2'd0 || mc4 !== 2'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d %0d %0d %0d want 0", lu1, mc1, lu4, mc4);
        end
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic test_forward_exmem();
        ins_t st[3]; logic [8:0] w[3]; logic [8:0] e;
        do_reset();
        st[0] = mk(1, 1, 2, 1, 3, 1, 0, 0, 0); w[0] = NRM;          // ADD $3,$1,$2
        st[1] = mk(1, 3, 5, 1, 4, 1, 0, 0, 0); w[1] = NRM;          // SUB $4,$3,$5
        st[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); w[2] = NRM | FA_EXM;
        for (int i = 0; i < 3; i++) begin
            drive(st[i]); exp_q.push_back(w[i]);
            @(negedge clock);
            e = exp_q.pop_front(); checks++;
            if (o1 !== e) begin errors++; $display("FAIL fwd_exmem[%0d]: got %b want %b", i, o1, e); end
            @(posedge clock); #1;
        end
        checks++;
        if (lu1 !== 16'd0 || mc1 !== 16'd0) begin
            errors++; $display("FAIL fwd_exmem_cnt: got %0d/%0d want 0/0", lu1, mc1);
        end
    endtask

    task automatic test_load_use();
        ins_t st[4]; logic [8:0] w[4]; logic [8:0] e;
        do_reset();
        st[0] = mk(1, 1, 2, 0, 2, 1, 1, 0, 0); w[0] = NRM;          // LW $2,0($1)
        st[1] = mk(1, 2, 3, 1, 4, 1, 0, 0, 0); w[1] = LUS;          // ADD $4,$2,$3 stalls
        st[2] = st[1];                          w[2] = NRM;          // ADD re-issued
        st[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); w[3] = NRM | FA_WB;
        for (int i = 0; i < 4; i++) begin
            drive(st[i]); exp_q.push_back(w[i]);
            @(negedge clock);
            e = exp_q.pop_front(); checks++;
            if (o1 !== e) begin errors++; $display("FAIL load_use[%0d]: got %b want %b", i, o1, e); end
            @(posedge clock); #1;
        end
        checks++;
        if (lu1 !== 16'd1) begin errors++; $display("FAIL load_use_cnt: got %0d want 1", lu1); end
    endtask

    task automatic test_mem_freeze();
        ins_t st[6]; logic [8:0] w[6]; logic [8:0] e;
        do_reset();
        st[0] = mk(1, 1, 2, 0, 2, 1, 1, 0, 0); w[0] = NRM;          // LW $2,0($1)
        st[1] = mk(1, 6, 7, 1, 5, 1, 0, 0, 0); w[1] = NRM;          // ADD $5,$6,$7
        st[2] = mk(1, 2, 3, 1, 4, 1, 0, 0, 0); w[2] = FRZ;          // ADD $4,$2,$3
        st[3] = st[2];                          w[3] = FRZ;
        st[4] = st[2];                          w[4] = NRM;
        st[5] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); w[5] = NRM | FA_WB;
        for (int i = 0; i < 6; i++) begin
            drive(st[i]); exp_q.push_back(w[i]);
            @(negedge clock);
            e = exp_q.pop_front(); checks++;
            if (o3 !== e) begin errors++; $display("FAIL mem_freeze[%0d]: got %b want %b", i, o3, e); end
            @(posedge clock); #1;
        end
        checks++;
        if (mc3 !== 16'd2 || lu3 !== 16'd0) begin
            errors++; $display("FAIL mem_freeze_cnt: got %0d/%0d want 2/0", mc3, lu3);
        end
    endtask

    task automatic test_flush_over_load_use();
        ins_t st[3]; logic [8:0] w[3]; logic [8:0] e;
        do_reset();
        st[0] = mk(1, 1, 2, 0, 2, 1, 1, 0, 0); w[0] = NRM;          // LW $2,0($1)
        st[1] = mk(1, 2, 3, 1, 4, 1, 0, 0, 1); w[1] = FLS;          // dependent + taken
        st[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); w[2] = NRM;
        for (int i = 0; i < 3; i++) begin
            drive(st[i]); exp_q.push_back(w[i]);
            @(negedge clock);
            e = exp_q.pop_front(); checks++;
            if (o1 !== e) begin errors++; $display("FAIL flush[%0d]: got %b want %b", i, o1, e); end
            @(posedge clock); #1;
        end
        checks++;
        if (lu1 !== 16'd0) begin errors++; $display("FAIL flush_lu_cnt: got %0d want 0", lu1); end
    endtask

    task automatic test_reg_zero();
        ins_t st[5]; logic [8:0] w[5]; logic [8:0] e;
        do_reset();
        st[0] = mk(1, 1, 2, 1, 0, 1, 0, 0, 0); w[0] = NRM;          // ADD $0,$1,$2
        st[1] = mk(1, 0, 0, 1, 5, 1, 0, 0, 0); w[1] = NRM;          // ADD $5,$0,$0
        st[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); w[2] = NRM;          // no forward from $0
        st[3] = mk(1, 1, 0, 0, 0, 1, 1, 0, 0); w[3] = NRM;          // LW $0,0($1)
        st[4] = mk(1, 0, 0, 1, 6, 1, 0, 0, 0); w[4] = NRM;          // ADD $6,$0,$0: no stall
        for (int i = 0; i < 5; i++) begin
            drive(st[i]); exp_q.push_back(w[i]);
            @(negedge clock);
            e = exp_q.pop_front(); checks++;
            if (o1 !== e) begin errors++; $display("FAIL reg_zero[%0d]: got %b want %b", i, o1, e); end
            @(posedge clock); #1;
        end
        checks++;
        if (lu1 !== 16'd0) begin errors++; $display("FAIL reg_zero_cnt: got %0d want 0", lu1); end
    endtask

    task automatic test_reset_mid_freeze();
        ins_t st[3]; logic [8:0] w[3]; logic [8:0] e;
        do_reset();
        st[0] = mk(1, 1, 2, 0, 2, 1, 1, 0, 0); w[0] = NRM;          // LW
        st[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); w[1] = NRM;
        st[2] = st[1];                          w[2] = FRZ;          // 1st freeze cycle
        for (int i = 0; i < 3; i++) begin
            drive(st[i]); exp_q.push_back(w[i]);
            @(negedge clock);
            e = exp_q.pop_front(); checks++;
            if (o4 !== e) begin errors++; $display("FAIL mid_reset[%0d]: got %b want %b", i, o4, e); end
            @(posedge clock); #1;
        end
        reset = 1'b1;                                                // 2nd freeze cycle
        exp_q.push_back(NRM);
        @(negedge clock);
        e = exp_q.pop_front(); checks++;
        if (o4 !== e) begin errors++; $display("FAIL mid_reset_forced: got %b want %b", o4, e); end
        @(posedge clock); #1;
        reset = 1'b0;
        exp_q.push_back(NRM);
        @(negedge clock);
        e = exp_q.pop_front(); checks++;
        if (o4 !== e) begin errors++; $display("FAIL mid_reset_after: got %b want %b", o4, e); end
        checks++;
        if (mc4 !== 2'd0 || lu4 !== 2'd0) begin
            errors++; $display("FAIL mid_reset_cnt: got %0d/%0d want 0/0", mc4, lu4);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int p = 0; p < 5; p++) begin
            drive(mk(1, 1, 2, 0, 2, 1, 1, 0, 0));                    // LW $2,0($1)
            @(posedge clock); #1;
            drive(mk(1, 2, 3, 1, 4, 1, 0, 0, 0));                    // ADD $4,$2,$3
            repeat (5) begin @(posedge clock); #1; end
        end
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) begin @(posedge clock); #1; end
        @(negedge clock);
        checks++;
        if (lu4 !== 2'd3) begin errors++; $display("FAIL sat_lu: got %0d want 3", lu4); end
        checks++;
        if (mc4 !== 2'd3) begin errors++; $display("FAIL sat_ms: got %0d want 3", mc4); end
        checks++;
        if (lu1 !== 16'd5 || mc1 !== 16'd0) begin
            errors++; $display("FAIL sat_u1_cnt: got %0d/%0d want 5/0", lu1, mc1);
        end
        @(posedge clock); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        test_reset();
        test_forward_exmem();
        test_load_use();
        test_mem_freeze();
        test_flush_over_load_use();
        test_reg_zero();
        test_reset_mid_freeze();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
